// File: rtl/serial_port_pkg.sv
// Shared frame constants and FSM state encodings for the serial port bridge.
// No logic, no latency.
// No flow control; consumed by serial_port and its bench.
package serial_pkg;

    localparam int DATA_BITS        = 8;
    localparam int STOP_BITS        = 1;
    localparam int BAUD_DIV_DEFAULT = 434;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/serial_port_if.sv
// Datapath-side byte bus of the serial port: write strobe, read strobe, status.
// Pure wiring, no latency.
// tx_ready_out gates writes; rd_valid_out/rd_en_in form the read handshake.
interface serial_port_if;

    logic [7:0] wr_data_in;
    logic       wr_en_in;
    logic       rd_en_in;
    logic [7:0] rd_data_out;
    logic       rd_valid_out;
    logic       tx_ready_out;

    modport master (
        output wr_data_in, wr_en_in, rd_en_in,
        input  rd_data_out, rd_valid_out, tx_ready_out
    );

    modport slave (
        input  wr_data_in, wr_en_in, rd_en_in,
        output rd_data_out, rd_valid_out, tx_ready_out
    );

endinterface

// File: rtl/serial_port_fifo.sv
// Generic synchronous FIFO with head-of-queue output and next-cycle level.
// Push visible at dout_o one edge after the push; level_nxt_o is combinational.
// Push while full is dropped unless a pop happens in the same cycle.
module serial_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic [AW:0]      level_nxt_o
);

    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full || pop_ok);
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        level_nxt_o = level_q;
        if (push_ok && !pop_ok) begin
            level_nxt_o = level_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            level_nxt_o = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_nxt_o;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/serial_port.sv
// Byte bridge between datapath and UART pins: TX FIFO + 8N1 shifter, RX deserializer.
// TX start bit on the pin 2 edges after an accepted write; RX valid ~9.5 bit times after start.
// Writes blocked by tx_ready_out (TX FIFO full); RX overrun drops new bytes. Option: SERIAL_PORT_RX_FIFO_EN.
module serial_port
    import serial_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    serial_port_if.slave  bus,
    input  logic          uart_rx_in,
    output logic          uart_tx_out
);

    localparam int               CNT_W     = $clog2(BAUD_DIV);
    localparam int               LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = FIFO_DEPTH[LVL_W-1:0];

    // ---------------- TX ----------------
    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shr_q, tx_shr_d;
    logic             tx_line_q, tx_line_d;
    logic             tx_ready_q;
    logic             tx_cnt_end;
    logic             tx_pop;
    logic [7:0]       tx_fifo_dout;
    logic             tx_fifo_empty;
    logic [LVL_W-1:0] tx_level_nxt;

    serial_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk         (clock),
        .rst_n       (reset),
        .push_i      (bus.wr_en_in),
        .pop_i       (tx_pop),
        .din_i       (bus.wr_data_in),
        .dout_o      (tx_fifo_dout),
        .empty_o     (tx_fifo_empty),
        .level_nxt_o (tx_level_nxt)
    );

    assign tx_cnt_end = (tx_cnt_q == CNT_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_end ? '0 : tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shr_d   = tx_shr_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!tx_fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shr_d   = tx_fifo_dout;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_end) begin
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_end) begin
                    tx_shr_d = {1'b0, tx_shr_q[7:1]};
                    tx_bit_d = tx_bit_q + 1'b1;
                    if (tx_bit_q == BIT_LAST) begin
                        tx_bit_d   = '0;
                        tx_state_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt_end) begin
                    tx_bit_d = tx_bit_q + 1'b1;
                    if (tx_bit_q == STOP_LAST) begin
                        // Chain straight into the next start bit when more bytes wait.
                        tx_bit_d   = '0;
                        tx_state_d = TX_IDLE;
                        if (!tx_fifo_empty) begin
                            tx_pop     = 1'b1;
                            tx_shr_d   = tx_fifo_dout;
                            tx_state_d = TX_START;
                        end
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_line_d = 1'b1;
        unique case (tx_state_q)
            TX_START: tx_line_d = 1'b0;
            TX_DATA:  tx_line_d = tx_shr_q[0];
            default:  tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shr_q   <= '0;
            tx_line_q  <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shr_q   <= tx_shr_d;
            tx_line_q  <= tx_line_d;
            tx_ready_q <= (tx_level_nxt != FULL_LVL);
        end
    end

    assign uart_tx_out      = tx_line_q;
    assign bus.tx_ready_out = tx_ready_q;

    // ---------------- RX ----------------
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shr_q, rx_shr_d;
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic             rx_cnt_end;
    logic             rx_deliver;

    assign rx_cnt_end = (rx_cnt_q == CNT_LAST);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_end ? '0 : rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shr_d   = rx_shr_q;
        rx_deliver = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                // A falling edge needs the line to have been high first, which also
                // holds off restarts after a framing error until the line recovers.
                if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_end) begin
                    rx_shr_d = {rx_s2_q, rx_shr_q[7:1]};
                    rx_bit_d = rx_bit_q + 1'b1;
                    if (rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_end) begin
                    rx_deliver = rx_s2_q;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shr_q   <= '0;
        end else begin
            rx_s1_q    <= uart_rx_in;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shr_q   <= rx_shr_d;
        end
    end

`ifdef SERIAL_PORT_RX_FIFO_EN
    logic [7:0]       rx_fifo_dout;
    logic             rx_fifo_empty;
    logic [LVL_W-1:0] rx_level_unused;

    serial_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk         (clock),
        .rst_n       (reset),
        .push_i      (rx_deliver),
        .pop_i       (bus.rd_en_in),
        .din_i       (rx_shr_q),
        .dout_o      (rx_fifo_dout),
        .empty_o     (rx_fifo_empty),
        .level_nxt_o (rx_level_unused)
    );

    assign bus.rd_data_out  = rx_fifo_empty ? 8'h00 : rx_fifo_dout;
    assign bus.rd_valid_out = !rx_fifo_empty;
`else
    logic [7:0] rx_hold_q;
    logic       rx_valid_q;

    // A read in the delivery cycle frees the register, so the new byte still lands.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_hold_q  <= '0;
            rx_valid_q <= 1'b0;
        end else if (rx_deliver && (!rx_valid_q || bus.rd_en_in)) begin
            rx_hold_q  <= rx_shr_q;
            rx_valid_q <= 1'b1;
        end else if (bus.rd_en_in) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign bus.rd_data_out  = rx_hold_q;
    assign bus.rd_valid_out = rx_valid_q;
`endif

endmodule

// File: tb/tb_serial_port.sv
// Directed bench for serial_port with an 8N1 frame at 4 clocks per bit.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_serial_port;

    localparam int BD    = 4;
    localparam int DEPTH = 8;

    logic clock      = 1'b0;
    logic reset      = 1'b1;
    logic uart_rx_in = 1'b1;
    logic uart_tx_out;

    int checks = 0;
    int errors = 0;

    logic cap_en = 1'b0;
    logic cap_q[$];

    serial_port_if bus_if();

    serial_port #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus_if),
        .uart_rx_in  (uart_rx_in),
        .uart_tx_out (uart_tx_out)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (cap_en) cap_q.push_back(uart_tx_out);
    end

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, data, 1'b0};
        @(negedge clock);
        for (int b = 0; b < 10; b++) begin
            uart_rx_in = fr[b];
            repeat (BD) @(negedge clock);
        end
        uart_rx_in = 1'b1;
    endtask

    task automatic pulse_read();
        bus_if.rd_en_in = 1'b1;
        @(negedge clock);
        bus_if.rd_en_in = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (bus_if.rd_valid_out !== 1'b1 && n < 30) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (uart_tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx_out); end
        checks++;
        if (bus_if.rd_valid_out !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", bus_if.rd_valid_out); end
        checks++;
        if (bus_if.tx_ready_out !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", bus_if.tx_ready_out); end
        checks++;
        if (bus_if.rd_data_out !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", bus_if.rd_data_out); end
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_tx_frame();
        logic [9:0] frame;
        frame = {1'b1, 8'h55, 1'b0};
        @(negedge clock);
        bus_if.wr_data_in = 8'h55;
        bus_if.wr_en_in   = 1'b1;
        @(negedge clock);
        bus_if.wr_en_in   = 1'b0;
        checks++;
        if (uart_tx_out !== 1'b1) begin errors++; $display("FAIL tx_idle_edge_n: got %b expected 1", uart_tx_out); end
        @(negedge clock);
        checks++;
        if (uart_tx_out !== 1'b1) begin errors++; $display("FAIL tx_idle_edge_n1: got %b expected 1", uart_tx_out); end
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < BD; c++) begin
                @(negedge clock);
                checks++;
                if (uart_tx_out !== frame[b]) begin
                    errors++;
                    $display("FAIL tx_frame_55 bit %0d cycle %0d: got %b expected %b", b, c, uart_tx_out, frame[b]);
                end
            end
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_tx_overflow();
        int s;
        int zeros;
        cap_q.delete();
        cap_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i == 8) begin
                checks++;
                if (bus_if.tx_ready_out !== 1'b1) begin errors++; $display("FAIL ovf_ready_before_9th: got %b expected 1", bus_if.tx_ready_out); end
            end
            if (i == 9) begin
                checks++;
                if (bus_if.tx_ready_out !== 1'b0) begin errors++; $display("FAIL ovf_ready_after_9th: got %b expected 0", bus_if.tx_ready_out); end
            end
            bus_if.wr_data_in = 8'(i);
            bus_if.wr_en_in   = 1'b1;
        end
        @(negedge clock);
        bus_if.wr_en_in = 1'b0;
        repeat (9 * 10 * BD + 60) @(negedge clock);
        cap_en = 1'b0;

        s = -1;
        for (int i = 0; i < cap_q.size(); i++) begin
            if (cap_q[i] == 1'b0) begin
                s = i;
                break;
            end
        end
        checks++;
        if (s < 0 || s > 10) begin
            errors++;
            $display("FAIL ovf_first_start: got index %0d expected 0..10", s);
        end else begin
            for (int f = 0; f < 9; f++) begin
                logic [9:0] frame;
                logic [7:0] obs;
                logic       ok;
                int         idx;
                frame = {1'b1, 8'(f), 1'b0};
                ok    = 1'b1;
                obs   = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < BD; c++) begin
                        idx = s + f * 10 * BD + b * BD + c;
                        if (idx >= cap_q.size()) ok = 1'b0;
                        else if (cap_q[idx] !== frame[b]) ok = 1'b0;
                    end
                    idx = s + f * 10 * BD + b * BD + 1;
                    if (b >= 1 && b <= 8 && idx < cap_q.size()) obs[b-1] = cap_q[idx];
                end
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL ovf_frame %0d: got byte %h (or bad framing) expected %h", f, obs, 8'(f));
                end
            end
            zeros = 0;
            for (int i = s + 9 * 10 * BD; i < cap_q.size(); i++) begin
                if (cap_q[i] !== 1'b1) zeros++;
            end
            checks++;
            if (zeros != 0) begin
                errors++;
                $display("FAIL ovf_tenth_dropped: got %0d low cycles after 9 frames expected 0", zeros);
            end
        end
    endtask

    task automatic test_rx_byte();
        send_frame(8'hA3, 1'b1);
        wait_valid();
        checks++;
        if (bus_if.rd_valid_out !== 1'b1) begin errors++; $display("FAIL rx_a3_valid: got %b expected 1", bus_if.rd_valid_out); end
        checks++;
        if (bus_if.rd_data_out !== 8'hA3) begin errors++; $display("FAIL rx_a3_data: got %h expected a3", bus_if.rd_data_out); end
        pulse_read();
        checks++;
        if (bus_if.rd_valid_out !== 1'b0) begin errors++; $display("FAIL rx_a3_read_clears: got %b expected 0", bus_if.rd_valid_out); end
        repeat (BD) @(negedge clock);
    endtask

    task automatic test_rx_errors();
        @(negedge clock);
        uart_rx_in = 1'b0;
        @(negedge clock);
        uart_rx_in = 1'b1;
        repeat (12 * BD) @(negedge clock);
        checks++;
        if (bus_if.rd_valid_out !== 1'b0) begin errors++; $display("FAIL rx_glitch: got valid %b expected 0", bus_if.rd_valid_out); end

        send_frame(8'hA3, 1'b0);
        repeat (3 * BD) @(negedge clock);
        checks++;
        if (bus_if.rd_valid_out !== 1'b0) begin errors++; $display("FAIL rx_framing_err: got valid %b expected 0", bus_if.rd_valid_out); end

        send_frame(8'h3C, 1'b1);
        wait_valid();
        checks++;
        if (bus_if.rd_valid_out !== 1'b1) begin errors++; $display("FAIL rx_3c_valid: got %b expected 1", bus_if.rd_valid_out); end
        checks++;
        if (bus_if.rd_data_out !== 8'h3C) begin errors++; $display("FAIL rx_3c_data: got %h expected 3c", bus_if.rd_data_out); end
        pulse_read();
        repeat (BD) @(negedge clock);
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1);
        wait_valid();
        checks++;
        if (bus_if.rd_data_out !== 8'h11) begin errors++; $display("FAIL ovr_first_data: got %h expected 11", bus_if.rd_data_out); end
        repeat (2 * BD) @(negedge clock);
        send_frame(8'h22, 1'b1);
        repeat (20) @(negedge clock);
        checks++;
        if (bus_if.rd_valid_out !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", bus_if.rd_valid_out); end
        checks++;
        if (bus_if.rd_data_out !== 8'h11) begin errors++; $display("FAIL ovr_held_data: got %h expected 11", bus_if.rd_data_out); end
        pulse_read();
`ifdef SERIAL_PORT_RX_FIFO_EN
        checks++;
        if (bus_if.rd_valid_out !== 1'b1) begin errors++; $display("FAIL ovr_fifo_second_valid: got %b expected 1", bus_if.rd_valid_out); end
        checks++;
        if (bus_if.rd_data_out !== 8'h22) begin errors++; $display("FAIL ovr_fifo_second_data: got %h expected 22", bus_if.rd_data_out); end
        pulse_read();
`endif
        checks++;
        if (bus_if.rd_valid_out !== 1'b0) begin errors++; $display("FAIL ovr_drained: got valid %b expected 0", bus_if.rd_valid_out); end

        // Read strobe lands on the same edge as the 0x22 delivery.
        repeat (2 * BD) @(negedge clock);
        send_frame(8'h11, 1'b1);
        wait_valid();
        repeat (2 * BD) @(negedge clock);
        send_frame(8'h22, 1'b1);
        pulse_read();
        checks++;
        if (bus_if.rd_valid_out !== 1'b1) begin errors++; $display("FAIL coinc_valid: got %b expected 1", bus_if.rd_valid_out); end
        checks++;
        if (bus_if.rd_data_out !== 8'h22) begin errors++; $display("FAIL coinc_data: got %h expected 22", bus_if.rd_data_out); end
        repeat (2) @(negedge clock);
        pulse_read();
        checks++;
        if (bus_if.rd_valid_out !== 1'b0) begin errors++; $display("FAIL coinc_drained: got valid %b expected 0", bus_if.rd_valid_out); end
    endtask

    task automatic test_reset_midframe();
        int zeros;
        @(negedge clock);
        bus_if.wr_data_in = 8'h00;
        bus_if.wr_en_in   = 1'b1;
        @(negedge clock);
        @(negedge clock);
        bus_if.wr_en_in   = 1'b0;
        repeat (10) @(negedge clock);
        checks++;
        if (uart_tx_out !== 1'b0) begin errors++; $display("FAIL midframe_line_low: got %b expected 0", uart_tx_out); end
        reset = 1'b0;
        #1;
        checks++;
        if (uart_tx_out !== 1'b1) begin errors++; $display("FAIL midframe_async_tx: got %b expected 1", uart_tx_out); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (bus_if.tx_ready_out !== 1'b1) begin errors++; $display("FAIL midframe_ready: got %b expected 1", bus_if.tx_ready_out); end
        checks++;
        if (bus_if.rd_data_out !== 8'h00) begin errors++; $display("FAIL midframe_rd_data: got %h expected 00", bus_if.rd_data_out); end
        zeros = 0;
        for (int i = 0; i < 15 * BD; i++) begin
            @(negedge clock);
            if (uart_tx_out !== 1'b1) zeros++;
        end
        checks++;
        if (zeros != 0) begin errors++; $display("FAIL midframe_fifo_flushed: got %0d low cycles expected 0", zeros); end
    endtask

    initial begin
        bus_if.wr_data_in = 8'h00;
        bus_if.wr_en_in   = 1'b0;
        bus_if.rd_en_in   = 1'b0;
        test_reset();
        test_tx_frame();
        test_tx_overflow();
        test_rx_byte();
        test_rx_errors();
        test_overrun();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
